// File: rtl/sp_wb_arb.sv
// Round-robin two-master arbiter for the SP's byte-wide Wishbone bus. The grant is
// locked for a whole cyc tenure, and a per-transfer watchdog aborts hung slave cycles.
module sp_wb_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [0:23] m0_adr_i,
    input  logic [0:7]  m0_dat_i,
    output logic [0:7]  m0_dat_o,
    input  logic        m0_we_i,
    input  logic [0:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [0:23] m1_adr_i,
    input  logic [0:7]  m1_dat_i,
    output logic [0:7]  m1_dat_o,
    input  logic        m1_we_i,
    input  logic [0:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [0:23] wb_adr_o,
    output logic [0:7]  wb_dat_o,
    input  logic [0:7]  wb_dat_i,
    output logic        wb_we_o,
    output logic [0:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last;   // most recent winner; 1 after reset so master 0 wins first
    logic [7:0] wd;
    logic       abort;  // high during the single abort cycle

    logic gnt0;
    logic gnt1;
    logic stalled;

    assign gnt0    = (state == GNT0);
    assign gnt1    = (state == GNT1);
    assign stalled = wb_stb_o && !wb_ack_i;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            wd    <= 8'd0;
            abort <= 1'b0;
        end else begin
            abort <= stalled && (wd == WD_LAST);

            if (stalled) wd <= wd + 8'd1;
            else         wd <= 8'd0;

            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (last) begin
                            state <= GNT0;
                            last  <= 1'b0;
                        end else begin
                            state <= GNT1;
                            last  <= 1'b1;
                        end
                    end else if (m0_cyc_i) begin
                        state <= GNT0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                        last  <= 1'b1;
                    end
                end
                GNT0:    if (!m0_cyc_i) state <= IDLE;
                GNT1:    if (!m1_cyc_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Idle bus parks on master 0's address/data so the slave sees stable values.
    assign wb_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
    assign wb_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
    assign wb_we_o  = gnt1 ? m1_we_i  : m0_we_i;
    assign wb_sel_o = gnt1 ? m1_sel_i : m0_sel_i;

    assign wb_cyc_o = (gnt0 && m0_cyc_i) || (gnt1 && m1_cyc_i);
    assign wb_stb_o = !abort && ((gnt0 && m0_cyc_i && m0_stb_i) ||
                                 (gnt1 && m1_cyc_i && m1_stb_i));

    assign m0_dat_o = wb_dat_i;
    assign m1_dat_o = wb_dat_i;

    // The strobe is dropped in the abort cycle, so a late ack there never passes through.
    assign m0_ack_o = wb_ack_i && gnt0 && wb_stb_o;
    assign m1_ack_o = wb_ack_i && gnt1 && wb_stb_o;
    assign m0_err_o = abort && gnt0;
    assign m1_err_o = abort && gnt1;

    assign timeout_o = abort;

endmodule
